seven_segment_arbiter: RTL

- Time-slices the single 8-digit seven-segment display between NUM_REQ requesters.
- Each requester presents a 32-bit hex word (8 nibbles) plus a valid flag.
- The arbiter grants the display round-robin, holding each owner for DWELL_CYCLES.
- val_out drives the 32-bit value input of the seven-segment controller; grant_out/switch_out let clients and the debug LEDs know who owns the display.

---
 rtl/seven_segment_arbiter_if.sv | 23 ++
 rtl/seven_segment_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/seven_segment_arbiter_if.sv
// Request/response bundle between display clients and the seven-segment arbiter.
// The arbiter uses the slave view; the clients and the display side use master.
interface seven_segment_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    req_valid_in;
  logic [NUM_REQ-1:0]    req_lock_in;
  logic [32*NUM_REQ-1:0] req_val_in;
  logic [31:0]           val_out;
  logic [NUM_REQ-1:0]    grant_out;
  logic                  owner_valid_out;
  logic                  switch_out;

  modport slave (
    input  req_valid_in, req_lock_in, req_val_in,
    output val_out, grant_out, owner_valid_out, switch_out
  );

  modport master (
    output req_valid_in, req_lock_in, req_val_in,
    input  val_out, grant_out, owner_valid_out, switch_out
  );
endinterface

// File: rtl/seven_segment_arbiter.sv
// Round-robin time-slicing of one 8-digit seven-segment display between
// NUM_REQ requesters. Each owner holds the display for DWELL_CYCLES unless it
// drops out or locks the rotation. Every output is a register.
module seven_segment_arbiter #(
  parameter int          NUM_REQ      = 4,
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter logic [31:0] BLANK_VAL    = 32'h0000_0000
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  seven_segment_arbiter_if.slave   bus
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(DWELL_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  // First valid index after k, wrapping, ending at k itself.
  function automatic logic [IW-1:0] next_valid(input logic [IW-1:0] k,
                                               input logic [NUM_REQ-1:0] v);
    logic [IW-1:0] sel;
    logic          found;
    sel   = k;
    found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!found && v[(int'(k) + off) % NUM_REQ]) begin
        sel   = IW'((int'(k) + off) % NUM_REQ);
        found = 1'b1;
      end
    end
    return sel;
  endfunction

  state_t             r_state;
  logic [IW-1:0]      r_owner;
  logic [CW-1:0]      r_cnt;
  logic [31:0]        r_val;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_owner_vld;
  logic               r_switch;

  logic [IW-1:0]      w_prev;
  logic [IW-1:0]      w_nv_owner;
  logic [IW-1:0]      w_nv_idle;
  logic [NUM_REQ-1:0] w_owner_oh;
  logic [NUM_REQ-1:0] w_nv_owner_oh;
  logic [NUM_REQ-1:0] w_nv_idle_oh;
  logic               w_any;
  logic               w_others;
  logic               w_owner_vld;
  logic               w_owner_lock;
  logic [31:0]        w_owner_word;
  logic [31:0]        w_nv_owner_word;
  logic [31:0]        w_nv_idle_word;

  // The IDLE search starts at the stored owner itself (next valid after owner-1).
  assign w_prev          = (r_owner == '0) ? IW'(NUM_REQ - 1) : r_owner - 1'b1;
  assign w_nv_owner      = next_valid(r_owner, bus.req_valid_in);
  assign w_nv_idle       = next_valid(w_prev,  bus.req_valid_in);
  assign w_owner_oh      = NUM_REQ'(1) << r_owner;
  assign w_nv_owner_oh   = NUM_REQ'(1) << w_nv_owner;
  assign w_nv_idle_oh    = NUM_REQ'(1) << w_nv_idle;
  assign w_any           = |bus.req_valid_in;
  assign w_others        = |(bus.req_valid_in & ~w_owner_oh);
  assign w_owner_vld     = bus.req_valid_in[r_owner];
  assign w_owner_lock    = bus.req_lock_in[r_owner];
  assign w_owner_word    = bus.req_val_in[32*r_owner    +: 32];
  assign w_nv_owner_word = bus.req_val_in[32*w_nv_owner +: 32];
  assign w_nv_idle_word  = bus.req_val_in[32*w_nv_idle  +: 32];

  // Ownership FSM: selects owner, runs the dwell counter and registers outputs.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= IDLE;
      r_owner     <= '0;
      r_cnt       <= '0;
      r_val       <= BLANK_VAL;
      r_grant     <= '0;
      r_owner_vld <= 1'b0;
      r_switch    <= 1'b0;
    end else begin
      r_switch <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_state     <= SHOW;
            r_owner     <= w_nv_idle;
            r_grant     <= w_nv_idle_oh;
            r_val       <= w_nv_idle_word;
            r_owner_vld <= 1'b1;
            r_switch    <= 1'b1;
          end else begin
            r_val       <= BLANK_VAL;
            r_grant     <= '0;
            r_owner_vld <= 1'b0;
          end
        end
        SHOW: begin
          if (!w_owner_vld) begin
            // Drop-out wins over dwell expiry and ignores the lock.
            r_cnt    <= '0;
            r_switch <= 1'b1;
            if (w_others) begin
              r_owner <= w_nv_owner;
              r_grant <= w_nv_owner_oh;
              r_val   <= w_nv_owner_word;
            end else begin
              // Owner index is kept so fairness resumes from here.
              r_state     <= IDLE;
              r_grant     <= '0;
              r_val       <= BLANK_VAL;
              r_owner_vld <= 1'b0;
            end
          end else if (r_cnt == LAST && !w_owner_lock) begin
            r_cnt    <= '0;
            r_owner  <= w_nv_owner;
            r_grant  <= w_nv_owner_oh;
            r_val    <= w_nv_owner_word;
            r_switch <= (w_nv_owner != r_owner);
          end else begin
            // Locked owners saturate at LAST and rotate once the lock drops.
            if (r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
            r_val <= w_owner_word;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.val_out         = r_val;
  assign bus.grant_out       = r_grant;
  assign bus.owner_valid_out = r_owner_vld;
  assign bus.switch_out      = r_switch;

endmodule
